// File: rtl/fpu_pkg.sv
// Shared FPU types and constants.
// Used by the converters and the add/mul datapaths.
package fpu_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;

    typedef struct packed {
        logic                 s;
        logic [FP_EXP_W-1:0]  e;
        logic [FP_FRAC_W-1:0] f;
    } fp32_t;

    typedef struct packed {
        logic        s;
        logic        z;
        logic [31:0] a;
    } itof_s1_t;

    // The normalised MSB is implicit, so only n[30:0] is carried.
    typedef struct packed {
        logic                s;
        logic                z;
        logic [FP_EXP_W-1:0] e;
        logic [30:0]         n;
    } itof_s2_t;

endpackage

// File: rtl/lzc32.sv
// 32-bit leading-zero counter, purely combinational.
// Count is 0 for a zero input; callers carry their own zero flag.
module lzc32 (
    input  logic [31:0] a,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) cnt = 5'(31 - i);
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Integer to single-precision converter, round to nearest even.
// Three stages: sign/magnitude, normalise, round and pack.
module itof_pipe
    import fpu_pkg::*;
#(
    parameter logic SIGNED_IN = 1'b1
) (
    input  logic        sys_clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    logic     v1, v2, v3;
    logic     r1, r2, r3;
    itof_s1_t st1, st1_d;
    itof_s2_t st2, st2_d;
    fp32_t    y3, y3_d;

    // Bubbles collapse: a stage may load whenever it is empty.
    assign r3        = ~v3 | out_ready;
    assign r2        = ~v2 | r3;
    assign r1        = ~v1 | r2;
    assign in_ready  = r1;
    assign out_valid = v3;
    assign y         = y3;

    logic s_in;
    assign s_in = SIGNED_IN & x[31];

    always_comb begin
        st1_d   = '0;
        st1_d.s = s_in;
        st1_d.a = s_in ? (~x + 32'd1) : x;
        st1_d.z = (x == 32'd0);
    end

    logic [4:0] lz;

    lzc32 u_lzc (
        .a   (st1.a),
        .cnt (lz)
    );

    always_comb begin
        st2_d   = '0;
        st2_d.s = st1.s;
        st2_d.z = st1.z;
        st2_d.e = 8'(FP_BIAS + 31) - {3'd0, lz};
        st2_d.n = st1.a[30:0] << lz;
    end

    logic        rnd;
    logic [23:0] sum;

    assign rnd = st2.n[7] & ((|st2.n[6:0]) | st2.n[8]);
    assign sum = {1'b0, st2.n[30:8]} + {23'd0, rnd};

    // On mantissa carry sum[22:0] is already zero.
    always_comb begin
        y3_d = '0;
        if (!st2.z) begin
            y3_d.s = st2.s;
            y3_d.e = st2.e + {7'd0, sum[23]};
            y3_d.f = sum[22:0];
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            st1 <= '0;
            st2 <= '0;
            y3  <= '0;
        end else begin
            if (r1) begin
                v1  <= in_valid;
                st1 <= st1_d;
            end
            if (r2) begin
                v2  <= v1;
                st2 <= st2_d;
            end
            if (r3) begin
                v3  <= v2;
                y3  <= y3_d;
            end
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe, signed and unsigned instances.
// Reference is an arithmetic int-to-float model with explicit RNE.
module tb_itof_pipe;

    logic        sys_clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [31:0] x;
    logic        out_ready;
    logic        in_ready_s, out_valid_s, in_ready_u, out_valid_u;
    logic [31:0] y_s, y_u;

    int checks   = 0;
    int failures = 0;

    int          acc_c[$];
    int          oc[$];
    logic [31:0] os[$];
    logic [31:0] ou[$];
    int          rdy_err, hold_err, rdy_drop;

    always #5 sys_clk = ~sys_clk;

    itof_pipe #(.SIGNED_IN(1'b1)) dut_s (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .x         (x),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .y         (y_s)
    );

    itof_pipe #(.SIGNED_IN(1'b0)) dut_u (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready_u),
        .x         (x),
        .out_valid (out_valid_u),
        .out_ready (out_ready),
        .y         (y_u)
    );

    function automatic logic [31:0] ref_cvt(input logic [31:0] v, input bit sgn);
        bit                s;
        longint unsigned   m, q, rem, half;
        int                p, sh;
        logic [7:0]        ex;
        logic [63:0]       qb;
        s = sgn && v[31];
        m = s ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
        if (m == 0) return 32'd0;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                p++;
            end
        end
        ex = 8'(p + 127);
        qb = q;
        return {s, ex, qb[22:0]};
    endfunction

    function automatic logic [31:0] rnd_x();
        logic [31:0] pool[5];
        pool = '{32'd0, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return $urandom >> $urandom_range(0, 31);
            2: return -($urandom >> $urandom_range(0, 31));
            default: return pool[$urandom_range(0, 4)];
        endcase
    endfunction

    // Drives vals back to back, samples on negedge, records transfers.
    task automatic stream(input logic [31:0] vals[$], input int st_lo,
                          input int st_hi, input bit rnd, input int budget);
        int          idx = 0;
        int          k = 0;
        int          occ = 0;
        bit          prev_stall = 0;
        bit          exp_rdy;
        logic [31:0] pys = '0, pyu = '0;
        acc_c.delete(); oc.delete(); os.delete(); ou.delete();
        rdy_err = 0; hold_err = 0; rdy_drop = 0;
        while (k < budget && os.size() < vals.size()) begin
            in_valid  = (idx < vals.size());
            x         = in_valid ? vals[idx] : $urandom;
            out_ready = rnd ? ($urandom_range(0, 3) != 0)
                            : !(k >= st_lo && k <= st_hi);
            @(negedge sys_clk);
            exp_rdy = !(occ == 3 && !out_ready);
            if (in_ready_s !== exp_rdy || in_ready_u !== exp_rdy) rdy_err++;
            if (!in_ready_s) rdy_drop++;
            if (out_valid_s !== out_valid_u) hold_err++;
            if (prev_stall && (out_valid_s !== 1'b1 || y_s !== pys || y_u !== pyu))
                hold_err++;
            if (in_valid && in_ready_s) begin
                acc_c.push_back(k);
                idx++;
                occ++;
            end
            if (out_valid_s && out_ready) begin
                os.push_back(y_s);
                ou.push_back(y_u);
                oc.push_back(k);
                occ--;
            end
            prev_stall = out_valid_s && !out_ready;
            pys = y_s;
            pyu = y_u;
            @(posedge sys_clk);
            #1;
            k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        checks++;
        if (out_valid_s !== 1'b0 || out_valid_u !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got %b/%b want 0", out_valid_s, out_valid_u);
        end
        checks++;
        if (y_s !== 32'd0 || y_u !== 32'd0) begin
            failures++;
            $display("FAIL reset_y got %h/%h want 0", y_s, y_u);
        end
        @(negedge sys_clk) rstn = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (in_ready_s !== 1'b1 || in_ready_u !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b/%b want 1", in_ready_s, in_ready_u);
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_directed(input string nm, input logic [31:0] vals[$],
                                 input logic [31:0] want[$], input bit uns);
        stream(vals, -1, -1, 1'b0, 40);
        checks++;
        if (os.size() != vals.size()) begin
            failures++;
            $display("FAIL %s_count got %0d want %0d", nm, os.size(), vals.size());
        end
        for (int i = 0; i < os.size(); i++) begin
            checks++;
            if ((uns ? ou[i] : os[i]) !== want[i]) begin
                failures++;
                $display("FAIL %s_y[%0d] x=%h got %h want %h", nm, i, vals[i],
                         uns ? ou[i] : os[i], want[i]);
            end
            checks++;
            if ((uns ? os[i] : ou[i]) !== ref_cvt(vals[i], uns)) begin
                failures++;
                $display("FAIL %s_other[%0d] x=%h got %h want %h", nm, i, vals[i],
                         uns ? os[i] : ou[i], ref_cvt(vals[i], uns));
            end
            checks++;
            if (oc[i] - acc_c[i] != 3) begin
                failures++;
                $display("FAIL %s_lat[%0d] got %0d want 3", nm, i, oc[i] - acc_c[i]);
            end
        end
    endtask

    task automatic test_basic();
        test_directed("basic", '{32'd1, 32'hFFFF_FFFF, 32'd0},
                      '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000}, 1'b0);
    endtask

    task automatic test_rounding();
        test_directed("round", '{32'h8000_0000, 32'h7FFF_FFFF, 32'h00FF_FFFF},
                      '{32'hCF00_0000, 32'h4F00_0000, 32'h4B7F_FFFF}, 1'b0);
    endtask

    task automatic test_ties();
        test_directed("ties", '{32'd16777217, 32'd16777219, -32'd16777219},
                      '{32'h4B80_0000, 32'h4B80_0002, 32'hCB80_0002}, 1'b0);
    endtask

    task automatic test_unsigned();
        test_directed("unsig", '{32'hFFFF_FFFF, 32'h8000_0000},
                      '{32'h4F80_0000, 32'h4F00_0000}, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [31:0] vals[$];
        for (int i = 0; i < 8; i++) vals.push_back(rnd_x());
        stream(vals, 4, 9, 1'b0, 60);
        checks++;
        if (os.size() != 8) begin
            failures++;
            $display("FAIL bp_count got %0d want 8", os.size());
        end
        for (int i = 0; i < os.size(); i++) begin
            checks++;
            if (os[i] !== ref_cvt(vals[i], 1'b1) || ou[i] !== ref_cvt(vals[i], 1'b0)) begin
                failures++;
                $display("FAIL bp_y[%0d] x=%h got %h/%h want %h/%h", i, vals[i],
                         os[i], ou[i], ref_cvt(vals[i], 1'b1), ref_cvt(vals[i], 1'b0));
            end
        end
        checks++;
        if (rdy_err != 0) begin
            failures++;
            $display("FAIL bp_in_ready bad_cycles=%0d want 0", rdy_err);
        end
        checks++;
        if (hold_err != 0) begin
            failures++;
            $display("FAIL bp_hold unstable_cycles=%0d want 0", hold_err);
        end
        checks++;
        if (rdy_drop == 0) begin
            failures++;
            $display("FAIL bp_full in_ready_low_cycles=0 want >0");
        end
    endtask

    task automatic test_random();
        logic [31:0] vals[$];
        int          bad = 0;
        for (int i = 0; i < 300; i++) vals.push_back(rnd_x());
        stream(vals, 0, -1, 1'b1, 2000);
        checks++;
        if (os.size() != 300) begin
            failures++;
            $display("FAIL rand_count got %0d want 300", os.size());
        end
        for (int i = 0; i < os.size(); i++) begin
            checks++;
            if (os[i] !== ref_cvt(vals[i], 1'b1) || ou[i] !== ref_cvt(vals[i], 1'b0)) begin
                failures++;
                if (bad++ < 10)
                    $display("FAIL rand_y[%0d] x=%h got %h/%h want %h/%h", i, vals[i],
                             os[i], ou[i], ref_cvt(vals[i], 1'b1), ref_cvt(vals[i], 1'b0));
            end
        end
        checks++;
        if (rdy_err != 0 || hold_err != 0) begin
            failures++;
            $display("FAIL rand_handshake ready_err=%0d hold_err=%0d want 0/0",
                     rdy_err, hold_err);
        end
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = rnd_x() | 32'd1;
            @(posedge sys_clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0) begin
            failures++;
            $display("FAIL mid_full got valid=%b ready=%b want 1/0", out_valid_s, in_ready_s);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (out_valid_s !== 1'b0 || out_valid_u !== 1'b0 || y_s !== 32'd0) begin
            failures++;
            $display("FAIL mid_async got valid=%b/%b y=%h want 0/0/0",
                     out_valid_s, out_valid_u, y_s);
        end
        @(negedge sys_clk) rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            if (out_valid_s || out_valid_u) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL mid_stale got %0d stale cycles want 0", stale);
        end
        @(posedge sys_clk);
        #1;
        test_directed("mid_next", '{32'd2}, '{32'h4000_0000}, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_ties();
        test_unsigned();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
